mnist_layer_seq: RTL and testbench
==================================

MNIST_LAYER_SEQ -- requirements
Module: mnist_layer_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IN0, 784, layer-0 inputs per neuron.
- OUT0, 32, layer-0 neurons.
- IN1, 32, layer-1 inputs per neuron; always equals OUT0.
- OUT1, 10, layer-1 neurons (digit scores).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, request to begin one inference.
- busy, out, 1, high from the first sequencing cycle through the DONE cycle.
- done, out, 1, one-cycle pulse when all layers are complete.
- layer, out, 1, active layer: 0 = hidden, 1 = output.
- rd_en, out, 1, input/weight memory read strobe.
- in_addr, out, 10, input index: pixel RAM for layer 0, hidden buffer for layer 1.
- w_addr, out, 15, flat weight ROM address.
- mac_clr, out, 1, clear the accumulator.
- mac_en, out, 1, accumulate the current product.
- bias_add, out, 1, add the bias for out_addr to the accumulator.
- act_relu, out, 1, apply ReLU on write-back.
- out_wr, out, 1, write the accumulator result.
- out_addr, out, 5, neuron index for bias, write-back and score slot.

Function
REQ-003 The FSM SHALL use these states: IDLE, CLR, MAC, DRAIN, BIAS, WRITE, DONE.
REQ-004 In IDLE, if start is high at a rising edge, the block SHALL do all of the following at that edge:
- go to CLR;
- set layer=0, neuron=0, in_idx=0, w_addr=0.
REQ-005 In any state other than IDLE, start SHALL be ignored; the block never queues a start.
REQ-006 CLR SHALL last one cycle, with mac_clr=1 and in_idx=0, then go to MAC.
REQ-007 In MAC, each cycle SHALL do all of the following:
- drive rd_en=1, in_addr=in_idx, and the current w_addr;
- at the edge, increment in_idx and w_addr;
- go to DRAIN when in_idx equals IN-1 (IN = IN0 or IN1 per layer).
REQ-008 mac_en SHALL equal rd_en delayed by exactly one cycle, to match the one-cycle memory read latency; mac_en is therefore high in the DRAIN cycle.
REQ-009 w_addr SHALL NOT be reset between neurons or layers. It runs contiguously so that:
- layer-1 neuron 0 starts at OUT0*IN0 (25088);
- the last address issued is OUT0*IN0 + OUT1*IN1 - 1 (25407).
REQ-010 BIAS SHALL last one cycle with bias_add=1 and out_addr=neuron.
REQ-011 WRITE SHALL last one cycle with out_wr=1, out_addr=neuron, and act_relu set as follows:
- act_relu=1 when layer=0;
- act_relu=0 when layer=1, so the raw Q8.8 scores are kept.
REQ-012 The transition out of WRITE SHALL be:
- neuron < OUT-1: increment neuron and go to CLR;
- layer=0 and neuron=OUT0-1: set layer=1, neuron=0, and go to CLR;
- layer=1 and neuron=OUT1-1: go to DONE.
REQ-013 DONE SHALL last one cycle with done=1 and busy=1, then go to IDLE.
REQ-014 If start is still high in IDLE after DONE, a new inference SHALL begin at the next edge.
REQ-015 Each neuron SHALL take exactly IN+4 cycles (CLR 1 + MAC IN + DRAIN 1 + BIAS 1 + WRITE 1).
REQ-016 done SHALL be high exactly OUT0*(IN0+4) + OUT1*(IN1+4) + 1 cycles after the start-sampling edge. With default parameters this is 25577 cycles.
REQ-017 When busy=0, all strobes SHALL be 0: rd_en, mac_en, mac_clr, bias_add, out_wr, done.
REQ-018 When IN=1, MAC SHALL last a single cycle.

Reset
REQ-019 When rst is asserted, asynchronously and in any state, the block SHALL:
- force the state to IDLE;
- set every output to 0, including layer, in_addr, w_addr and out_addr;
- clear the internal counters and the mac_en delay register.
REQ-020 After rst deasserts, the block SHALL remain in IDLE until start is sampled high; any inference aborted by reset is not resumed.

Verification
REQ-021 Small parameters (IN0=4, OUT0=2, IN1=2, OUT1=3), start pulsed for 1 cycle:
- done rises 35 cycles after the sampling edge;
- in_addr sequence per layer-0 neuron is 0,1,2,3;
- w_addr runs 0..7, then 8..13;
- out_wr fires 5 times, with out_addr 0,1,0,1,2.
REQ-022 Same parameters, mac_en check:
- mac_en has the rd_en pattern shifted by one cycle;
- mac_clr pulses precede each neuron's first rd_en by 1 cycle;
- act_relu=1 on the first 2 writes and 0 on the last 3.
REQ-023 Same parameters, start held high for 2 cycles:
- only one inference runs;
- busy stays high for 35 cycles;
- exactly one done pulse occurs.
REQ-024 Same parameters, start held high continuously:
- a second inference begins the edge after the DONE cycle;
- done pulses recur every 36 cycles.
REQ-025 Same parameters, rst asserted mid-MAC of layer 1:
- all outputs read 0 immediately, without waiting for a clock edge;
- after release, busy stays 0 until start;
- a fresh inference starts again from w_addr=0.
REQ-026 Default parameters, single start:
- done occurs after 25577 cycles;
- the last w_addr issued is 25407;
- the last out_addr written is 9.

Source files
------------

// File: rtl/mnist_layer_seq.sv
// Control sequencer for a two-layer MNIST MLP: walks every neuron of the hidden
// and output layers, issuing memory reads, MAC, bias and write-back strobes.
module mnist_layer_seq #(
  parameter int IN0  = 784,
  parameter int OUT0 = 32,
  parameter int IN1  = 32,
  parameter int OUT1 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        layer,
  output logic        rd_en,
  output logic [9:0]  in_addr,
  output logic [14:0] w_addr,
  output logic        mac_clr,
  output logic        mac_en,
  output logic        bias_add,
  output logic        act_relu,
  output logic        out_wr,
  output logic [4:0]  out_addr
);

  typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, BIAS, WRITE, DONE} state_t;

  localparam logic [9:0] IN0_LAST  = 10'(IN0 - 1);
  localparam logic [9:0] IN1_LAST  = 10'(IN1 - 1);
  localparam logic [4:0] OUT0_LAST = 5'(OUT0 - 1);
  localparam logic [4:0] OUT1_LAST = 5'(OUT1 - 1);

  state_t      state_q, state_d;
  logic        layer_q, layer_d;
  logic [4:0]  neuron_q, neuron_d;
  logic [9:0]  in_idx_q, in_idx_d;
  logic [14:0] w_addr_q, w_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_en_q, rd_en_d;
  logic        mac_en_q, mac_en_d;
  logic        mac_clr_q, mac_clr_d;
  logic        bias_add_q, bias_add_d;
  logic        act_relu_q, act_relu_d;
  logic        out_wr_q, out_wr_d;
  logic        in_last_s;
  logic        out_last_s;

  // Next-state, counter updates and strobe decode of the upcoming state.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    in_idx_d = in_idx_q;
    w_addr_d = w_addr_q;

    in_last_s  = layer_q ? (in_idx_q == IN1_LAST) : (in_idx_q == IN0_LAST);
    out_last_s = layer_q ? (neuron_q == OUT1_LAST) : (neuron_q == OUT0_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLR;
          layer_d  = 1'b0;
          neuron_d = 5'd0;
          in_idx_d = 10'd0;
          w_addr_d = 15'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        in_idx_d = 10'd0;
        state_d  = MAC;
      end
      MAC: begin
        // w_addr is never rewound: the weight ROM is one flat image across layers
        in_idx_d = in_idx_q + 10'd1;
        w_addr_d = w_addr_q + 15'd1;
        if (in_last_s) begin
          state_d = DRAIN;
        end else begin
          state_d = MAC;
        end
      end
      DRAIN: state_d = BIAS;
      BIAS:  state_d = WRITE;
      WRITE: begin
        if (!out_last_s) begin
          neuron_d = neuron_q + 5'd1;
          state_d  = CLR;
        end else if (!layer_q) begin
          layer_d  = 1'b1;
          neuron_d = 5'd0;
          state_d  = CLR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    rd_en_d    = (state_d == MAC);
    mac_clr_d  = (state_d == CLR);
    bias_add_d = (state_d == BIAS);
    out_wr_d   = (state_d == WRITE);
    act_relu_d = (state_d == WRITE) && !layer_d;
    // one-cycle read latency: accumulate the data fetched by last cycle's read
    mac_en_d   = rd_en_q;
  end

  // State, counters and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= 1'b0;
      neuron_q   <= 5'd0;
      in_idx_q   <= 10'd0;
      w_addr_q   <= 15'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      bias_add_q <= 1'b0;
      act_relu_q <= 1'b0;
      out_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      neuron_q   <= neuron_d;
      in_idx_q   <= in_idx_d;
      w_addr_q   <= w_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      mac_en_q   <= mac_en_d;
      mac_clr_q  <= mac_clr_d;
      bias_add_q <= bias_add_d;
      act_relu_q <= act_relu_d;
      out_wr_q   <= out_wr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign layer    = layer_q;
  assign rd_en    = rd_en_q;
  assign in_addr  = in_idx_q;
  assign w_addr   = w_addr_q;
  assign mac_clr  = mac_clr_q;
  assign mac_en   = mac_en_q;
  assign bias_add = bias_add_q;
  assign act_relu = act_relu_q;
  assign out_wr   = out_wr_q;
  assign out_addr = neuron_q;

endmodule

// File: tb/tb_mnist_layer_seq.sv
// Directed bench for mnist_layer_seq: small-parameter instance for sequencing
// details, default-parameter instance for full-size latency and addressing.
module tb_mnist_layer_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_big = 1'b0;
  int   passed = 0;
  int   total = 0;

  logic        s_busy, s_done, s_layer, s_rd_en, s_mac_clr, s_mac_en;
  logic        s_bias_add, s_act_relu, s_out_wr;
  logic [9:0]  s_in_addr;
  logic [14:0] s_w_addr;
  logic [4:0]  s_out_addr;

  logic        b_busy, b_done, b_layer, b_rd_en, b_mac_clr, b_mac_en;
  logic        b_bias_add, b_act_relu, b_out_wr;
  logic [9:0]  b_in_addr;
  logic [14:0] b_w_addr;
  logic [4:0]  b_out_addr;

  logic [38:0] s_all, b_all;
  logic [5:0]  s_strobes;
  assign s_all = {s_busy, s_done, s_layer, s_rd_en, s_in_addr, s_w_addr, s_mac_clr,
                  s_mac_en, s_bias_add, s_act_relu, s_out_wr, s_out_addr};
  assign b_all = {b_busy, b_done, b_layer, b_rd_en, b_in_addr, b_w_addr, b_mac_clr,
                  b_mac_en, b_bias_add, b_act_relu, b_out_wr, b_out_addr};
  assign s_strobes = {s_rd_en, s_mac_en, s_mac_clr, s_bias_add, s_out_wr, s_done};

  always #5 clk = ~clk;

  mnist_layer_seq #(.IN0(4), .OUT0(2), .IN1(2), .OUT1(3)) u_small (
    .clk(clk), .rst(rst), .start(start), .busy(s_busy), .done(s_done),
    .layer(s_layer), .rd_en(s_rd_en), .in_addr(s_in_addr), .w_addr(s_w_addr),
    .mac_clr(s_mac_clr), .mac_en(s_mac_en), .bias_add(s_bias_add),
    .act_relu(s_act_relu), .out_wr(s_out_wr), .out_addr(s_out_addr)
  );

  mnist_layer_seq u_big (
    .clk(clk), .rst(rst), .start(start_big), .busy(b_busy), .done(b_done),
    .layer(b_layer), .rd_en(b_rd_en), .in_addr(b_in_addr), .w_addr(b_w_addr),
    .mac_clr(b_mac_clr), .mac_en(b_mac_en), .bias_add(b_bias_add),
    .act_relu(b_act_relu), .out_wr(b_out_wr), .out_addr(b_out_addr)
  );

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (s_all !== 39'd0) $display("FAIL reset_small: got %h expected 0", s_all);
    else passed++;
    total++;
    if (b_all !== 39'd0) $display("FAIL reset_big: got %h expected 0", b_all);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (s_busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b expected 0", s_busy);
    else passed++;
  endtask

  task automatic test_single();
    int exp_in [0:13]     = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 1, 0, 1};
    int exp_rd_cyc [0:13] = '{2, 3, 4, 5, 10, 11, 12, 13, 18, 19, 24, 25, 30, 31};
    int exp_clr [0:4]     = '{1, 9, 17, 23, 29};
    int exp_wr_cyc [0:4]  = '{8, 16, 22, 28, 34};
    int exp_oa [0:4]      = '{0, 1, 0, 1, 2};
    logic exp_relu [0:4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int rd_n = 0, wr_n = 0, clr_n = 0, busy_n = 0, done_n = 0, done_at = -1;
    logic prev_rd = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (s_busy) busy_n++;
      if (s_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      total++;
      if (s_mac_en !== prev_rd) $display("FAIL mac_en_delay c%0d: got %b expected %b", k, s_mac_en, prev_rd);
      else passed++;
      prev_rd = s_rd_en;
      if (s_rd_en) begin
        if (rd_n < 14) begin
          total++;
          if (s_in_addr !== 10'(exp_in[rd_n]) || s_w_addr !== 15'(rd_n) || k != exp_rd_cyc[rd_n])
            $display("FAIL read_%0d: got cyc %0d in %0d w %0d expected cyc %0d in %0d w %0d",
                     rd_n, k, s_in_addr, s_w_addr, exp_rd_cyc[rd_n], exp_in[rd_n], rd_n);
          else passed++;
        end
        rd_n++;
      end
      if (s_mac_clr) begin
        if (clr_n < 5) begin
          total++;
          if (k != exp_clr[clr_n]) $display("FAIL mac_clr_%0d: got cyc %0d expected %0d", clr_n, k, exp_clr[clr_n]);
          else passed++;
        end
        clr_n++;
      end
      if (s_out_wr) begin
        if (wr_n < 5) begin
          total++;
          if (k != exp_wr_cyc[wr_n] || s_out_addr !== 5'(exp_oa[wr_n]) || s_act_relu !== exp_relu[wr_n])
            $display("FAIL write_%0d: got cyc %0d addr %0d relu %b expected cyc %0d addr %0d relu %b",
                     wr_n, k, s_out_addr, s_act_relu, exp_wr_cyc[wr_n], exp_oa[wr_n], exp_relu[wr_n]);
          else passed++;
        end
        wr_n++;
      end
      if (!s_busy) begin
        total++;
        if (s_strobes !== 6'd0) $display("FAIL idle_strobes c%0d: got %b expected 000000", k, s_strobes);
        else passed++;
      end
    end
    total++;
    if (rd_n != 14) $display("FAIL read_count: got %0d expected 14", rd_n); else passed++;
    total++;
    if (clr_n != 5) $display("FAIL clr_count: got %0d expected 5", clr_n); else passed++;
    total++;
    if (wr_n != 5) $display("FAIL write_count: got %0d expected 5", wr_n); else passed++;
    total++;
    if (done_n != 1 || done_at != 35) $display("FAIL done_single: got %0d pulses at %0d expected 1 at 35", done_n, done_at);
    else passed++;
    total++;
    if (busy_n != 35) $display("FAIL busy_len: got %0d expected 35", busy_n); else passed++;
  endtask

  task automatic test_hold2();
    int busy_n = 0, done_n = 0, done_at = -1;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 2) start = 1'b0;
      if (s_busy) busy_n++;
      if (s_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    total++;
    if (busy_n != 35) $display("FAIL hold2_busy: got %0d expected 35", busy_n); else passed++;
    total++;
    if (done_n != 1 || done_at != 35) $display("FAIL hold2_done: got %0d pulses at %0d expected 1 at 35", done_n, done_at);
    else passed++;
    total++;
    if (s_busy !== 1'b0) $display("FAIL hold2_idle: busy got %b expected 0", s_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int done_n = 0;
    int d0 = -1, d1 = -1;
    start = 1'b1;
    for (int k = 1; k <= 71; k++) begin
      @(negedge clk);
      if (s_done) begin
        if (done_n == 0) d0 = k;
        if (done_n == 1) d1 = k;
        done_n++;
      end
      if (k == 36) begin
        total++;
        if (s_busy !== 1'b0) $display("FAIL b2b_gap: busy got %b expected 0", s_busy); else passed++;
      end
      if (k == 37) begin
        total++;
        if (s_mac_clr !== 1'b1) $display("FAIL b2b_restart_clr: got %b expected 1", s_mac_clr); else passed++;
      end
      if (k == 38) begin
        total++;
        if (s_rd_en !== 1'b1 || s_w_addr !== 15'd0)
          $display("FAIL b2b_restart_rd: got rd %b w %0d expected rd 1 w 0", s_rd_en, s_w_addr);
        else passed++;
      end
    end
    start = 1'b0;
    total++;
    if (done_n != 2 || d0 != 35 || d1 != 71)
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d expected 2 at 35,71", done_n, d0, d1);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (s_busy !== 1'b0) $display("FAIL b2b_stop: busy got %b expected 0", s_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int done_at = -1;
    start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    total++;
    if (s_layer !== 1'b1 || s_rd_en !== 1'b1 || s_w_addr !== 15'd8)
      $display("FAIL pre_reset: got layer %b rd %b w %0d expected 1 1 8", s_layer, s_rd_en, s_w_addr);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (s_all !== 39'd0) $display("FAIL async_reset: got %h expected 0", s_all); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (s_busy !== 1'b0) $display("FAIL post_reset_idle_%0d: busy got %b expected 0", k, s_busy); else passed++;
    end
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        total++;
        if (s_rd_en !== 1'b1 || s_w_addr !== 15'd0 || s_layer !== 1'b0)
          $display("FAIL fresh_start: got rd %b w %0d layer %b expected 1 0 0", s_rd_en, s_w_addr, s_layer);
        else passed++;
      end
      if (s_done && done_at < 0) done_at = k;
    end
    total++;
    if (done_at != 35) $display("FAIL fresh_done: got %0d expected 35", done_at); else passed++;
  endtask

  task automatic test_default();
    int done_at = -1;
    int last_w = -1, first_l1 = -1, last_oa = -1;
    start_big = 1'b1;
    for (int k = 1; k <= 25600 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) start_big = 1'b0;
      if (b_rd_en) begin
        last_w = int'(b_w_addr);
        if (b_layer && first_l1 < 0) first_l1 = int'(b_w_addr);
      end
      if (b_out_wr) last_oa = int'(b_out_addr);
      if (b_done) done_at = k;
    end
    total++;
    if (done_at != 25577) $display("FAIL big_done: got %0d expected 25577 (-1 = timeout)", done_at); else passed++;
    total++;
    if (last_w != 25407) $display("FAIL big_last_w: got %0d expected 25407", last_w); else passed++;
    total++;
    if (first_l1 != 25088) $display("FAIL big_l1_w: got %0d expected 25088", first_l1); else passed++;
    total++;
    if (last_oa != 9) $display("FAIL big_last_oa: got %0d expected 9", last_oa); else passed++;
    @(negedge clk);
    total++;
    if (b_done !== 1'b0 || b_busy !== 1'b0) $display("FAIL big_after: got done %b busy %b expected 0 0", b_done, b_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold2();
    test_back_to_back();
    test_reset_mid();
    test_default();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
